imem_fetch_responder: RTL
=========================

# imem_fetch_responder

Instruction-memory responder at the far end of the fetch path: accepts instruction-address requests from the program counter/fetch stage, reads a word-addressed on-chip instruction store after a configurable number of wait states, and returns the instruction word with an error flag. It also exposes a write port that the testbench or boot loader uses to preload the program.

## Interface

- DEPTH_WORDS, 256: number of 32-bit instruction words; power of two, 4..65536.
- LATENCY, 2: wait states between request acceptance and response; 0..15.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address of instruction.
- rsp_valid  output  1  response word valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_instr  output  32  instruction word.
- rsp_error  output  1  address misaligned or out of range.
- flush  input  1  abandon in-flight request (branch/jump redirect).
- wr_en  input  1  preload write strobe.
- wr_addr  input  32  byte address of preload word; bits [1:0] ignored.
- wr_data  input  32  preload data.

## Operation

- Storage: DEPTH_WORDS x 32 array, indexed by addr[log2(DEPTH_WORDS)+1:2]. Contents not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, accept: latch index and error; read array word into data register. Next state WAIT if LATENCY>0 (wait counter loaded with LATENCY-1), else RESP.
  - WAIT: req_ready=0; counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1, req_ready=0; held stable until rsp_ready=1, then IDLE.
- Error rule: rsp_error=1 if req_addr[1:0]!=0 or req_addr>=4*DEPTH_WORDS. On error rsp_instr=32'h00000013 (NOP) regardless of array contents.
- Data is sampled at acceptance: writes to the same word after acceptance do not change the in-flight response. Write and accept of the same word in the same cycle returns the old word.
- Writes (wr_en) are performed in any state, including during reset; out-of-range wr_addr is dropped.
- flush=1 in any state: next state IDLE, rsp_valid deasserts next cycle, and the in-flight response is discarded. A request presented together with flush is not accepted (req_ready forced to 0 while flush=1).
- rsp_instr/rsp_error are only meaningful when rsp_valid=1. They hold their last value otherwise.

## Timing

- Reset: state IDLE; req_ready=0 while reset is asserted and 1 in the cycle after release. rsp_valid=0, rsp_instr=0, rsp_error=0, wait counter=0.
- Accept at edge T -> rsp_valid high from cycle T+1+LATENCY.
- Response handshake completes at the edge where rsp_valid&&rsp_ready; req_ready rises the following cycle. Sustained throughput is one fetch per LATENCY+2 cycles.
- rsp_instr and rsp_error remain stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-transaction: the response is lost. Outputs take their reset values on the next edge.
- flush has priority over rsp_ready and the wait counter. reset has priority over flush.

## Test plan

- Preload word 0x00500093 at addr 0x0. After reset release, request addr 0x0 with LATENCY=2 -> rsp_valid exactly 3 cycles after accept, rsp_instr=0x00500093, rsp_error=0.
- Request addr 0x2, then addr 4*DEPTH_WORDS -> each returns rsp_error=1 and rsp_instr=0x00000013.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_instr and rsp_error stable, req_ready=0. Raise rsp_ready -> req_ready=1 on the next cycle.
- Accept addr 0x8 (old word 0x11111111) and write 0x22222222 to 0x8 one cycle later -> response is 0x11111111. A re-fetch returns 0x22222222.
- Assert flush during WAIT -> no rsp_valid for that request, req_ready=1 the next cycle. A new request to 0x4 returns correct data.
- Assert reset during RESP -> rsp_valid=0 and req_ready=0 next cycle, req_ready=1 one cycle after release. Repeat back-to-back fetches with LATENCY=0 -> rsp_valid on T+1.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// imem_fetch_responder
//
// Instruction-memory responder sitting at the far end of the fetch path. The
// fetch stage presents a byte address; the responder looks up a word-addressed
// on-chip instruction store, waits a configurable number of wait states, and
// returns the instruction word together with an error flag. A separate write
// port lets a boot loader (or a testbench) preload the program at any time.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit instruction words (power of two, 4..65536)
//   LATENCY     : wait states between request acceptance and response (0..15)
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset      : synchronous, active-high reset
//   req_valid  : fetch request present
//   req_ready  : responder can accept a request this cycle
//   req_addr   : byte address of the requested instruction
//   rsp_valid  : response word valid
//   rsp_ready  : consumer accepts the response
//   rsp_instr  : instruction word (NOP when rsp_error is set)
//   rsp_error  : request was misaligned or outside the store
//   flush      : abandon any in-flight request (branch/jump redirect)
//   wr_en      : preload write strobe
//   wr_addr    : byte address of the preload word, bits [1:0] ignored
//   wr_data    : preload data
// -----------------------------------------------------------------------------
module imem_fetch_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic        rsp_error,
   input  logic        flush,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // The wait counter is loaded with LATENCY-1 so that the WAIT state lasts
   // exactly LATENCY cycles; with no wait states the load value is unused.
   localparam logic [3:0]  WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t             state;
   logic [3:0]         wait_cnt;
   logic [31:0]        pend_instr;
   logic               pend_error;

   logic [31:0]        mem [DEPTH_WORDS];

   logic [IDX_W-1:0]   req_index;
   logic               req_misaligned;
   logic               req_out_of_range;
   logic               req_error;
   logic [31:0]        fetch_word;
   logic               accept;

   logic [IDX_W-1:0]   wr_index;
   logic               wr_in_range;
   logic               unused_wr_lsbs;

   // Address decode for the fetch side. Anything with address bits set above
   // the store, or not word aligned, is answered with a NOP and the error flag
   // instead of touching the array.
   assign req_index        = req_addr[IDX_W+1:2];
   assign req_misaligned   = (req_addr[1:0] != 2'b00);
   assign req_out_of_range = (req_addr[31:IDX_W+2] != '0);
   assign req_error        = req_misaligned || req_out_of_range;
   assign fetch_word       = req_error ? NOP_INSTR : mem[req_index];

   // Only IDLE accepts, and never while reset or flush is active, so a request
   // presented alongside a redirect is simply ignored by the fetch stage.
   assign req_ready = (state == IDLE) && !reset && !flush;
   assign accept    = req_valid && req_ready;

   // Preload side decode. The low two address bits carry no information for a
   // word store; they are folded into a dummy net so they are not flagged.
   assign wr_index       = wr_addr[IDX_W+1:2];
   assign wr_in_range    = (wr_addr[31:IDX_W+2] == '0);
   assign unused_wr_lsbs = ^wr_addr[1:0];

   // Instruction store write port. It is deliberately independent of reset and
   // of the FSM so a boot loader can load the program while the core is held
   // in reset. Writes beyond the store are dropped. Because this is a
   // non-blocking update, a fetch accepted on the same edge still sees the
   // previous word.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_index] <= wr_data;
      end
   end

   // Fetch FSM. The word is captured into pend_instr/pend_error at acceptance
   // so later writes cannot change an in-flight response; rsp_instr/rsp_error
   // are only reloaded when a response is actually presented, so they keep
   // their last value between responses. Priority is reset, then flush, then
   // normal sequencing, which lets a redirect cut through a pending wait or
   // an unconsumed response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         rsp_valid  <= 1'b0;
         rsp_instr  <= 32'h0;
         rsp_error  <= 1'b0;
         pend_instr <= 32'h0;
         pend_error <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (LATENCY == 0) begin
                     rsp_instr <= fetch_word;
                     rsp_error <= req_error;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     pend_instr <= fetch_word;
                     pend_error <= req_error;
                     wait_cnt   <= WAIT_LOAD;
                     state      <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  rsp_instr <= pend_instr;
                  rsp_error <= pend_error;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
